// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and control states.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SRL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_NOR   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_SRA   = 4'b1010,
    OP_MULTU = 4'b1100,
    OP_DIVU  = 4'b1101
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] code);
    return (code == OP_MULTU) || (code == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative engine: unsigned shift-add multiply or restoring divide,
// one bit per cycle, result as {hi, lo}.
module alu_mc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic             run;
  logic             mode;
  logic [WIDTH-1:0] opd;
  logic             cur_mode;
  logic [WIDTH-1:0] cur_hi, cur_lo, cur_opd;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  // The start cycle already performs the first step on the fresh operands,
  // so WIDTH steps finish by the time the counter has run down to zero.
  always_comb begin
    cur_mode  = start ? div : mode;
    cur_hi    = start ? '0 : hi;
    cur_lo    = start ? (div ? a : b) : lo;
    cur_opd   = start ? (div ? b : a) : opd;
    mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_opd} : '0);
    div_shift = {cur_hi, cur_lo[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, cur_opd};
    div_ge    = !div_trial[WIDTH+1];
    nxt_hi    = mul_sum[WIDTH:1];
    nxt_lo    = {mul_sum[0], cur_lo[WIDTH-1:1]};
    if (cur_mode) begin
      nxt_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
      nxt_lo = {cur_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      run  <= 1'b0;
      mode <= 1'b0;
      opd  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (start) begin
      cnt  <= CW'(WIDTH - 1);
      run  <= 1'b1;
      mode <= div;
      opd  <= cur_opd;
      hi   <= nxt_hi;
      lo   <= nxt_lo;
    end else if (run) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        hi  <= nxt_hi;
        lo  <= nxt_lo;
      end else begin
        run <= 1'b0;
      end
    end
  end

  assign busy = run;
  assign done = run && (cnt == '0);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU,
// with a valid/ready handshake on both sides.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_t           state, state_nxt;
  logic             accept, iter_op;
  logic             iter_busy, iter_done;
  logic [WIDTH-1:0] iter_hi, iter_lo;
  logic [WIDTH-1:0] sum, diff, res_y;
  logic             res_ovf, res_err;

  assign in_ready  = ((state == IDLE) || (state == DONE && out_ready)) && !iter_busy;
  assign accept    = in_valid && in_ready;
  assign iter_op   = is_iter_op(op);
  assign out_valid = (state == DONE);
  assign sum       = a + b;
  assign diff      = a - b;

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (accept && iter_op),
    .div     (op == OP_DIVU),
    .a       (a),
    .b       (b),
    .busy    (iter_busy),
    .done    (iter_done),
    .hi      (iter_hi),
    .lo      (iter_lo)
  );

  always_comb begin
    res_y   = '0;
    res_ovf = 1'b0;
    res_err = 1'b0;
    case (op_t'(op))
      OP_AND:  res_y = a & b;
      OP_OR:   res_y = a | b;
      OP_XOR:  res_y = a ^ b;
      OP_NOR:  res_y = ~(a | b);
      OP_ADD: begin
        res_y   = sum;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_y   = diff;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  res_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res_y = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  res_y = b << shamt;
      OP_SRL:  res_y = b >> shamt;
      OP_SRA:  res_y = $signed(b) >>> shamt;
      OP_MULTU, OP_DIVU: res_y = '0;
      default: res_err = 1'b1;
    endcase
  end

  // A consumed result in DONE can hand over straight to the next accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = iter_op ? BUSY : DONE;
      BUSY: if (iter_done) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = iter_op ? BUSY : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y    <= '0;
      hi   <= '0;
      zero <= 1'b0;
      ovf  <= 1'b0;
      err  <= 1'b0;
    end else if (accept && !iter_op) begin
      y    <= res_y;
      hi   <= '0;
      zero <= (res_y == '0);
      ovf  <= res_ovf;
      err  <= res_err;
    end else if (state == BUSY && iter_done) begin
      y    <= iter_lo;
      hi   <= iter_hi;
      zero <= (iter_lo == '0);
      ovf  <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operand/opcode offer.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  4  operation code (alu_mc_pkg::op_t).
REQ-010 shamt  input  SHW  shift amount.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 y  output  WIDTH  primary result.
REQ-014 hi  output  WIDTH  MULTU upper half or DIVU remainder; 0 for all other ops.
REQ-015 zero  output  1  y equals 0.
REQ-016 ovf  output  1  signed overflow for ADD/SUB; 0 otherwise.
REQ-017 err  output  1  undefined opcode flag.

Function
REQ-018 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0100 SLL b<<shamt, 0101 SRL b>>shamt, 0011 XOR, 1000 NOR, 1001 SLTU, 1010 SRA b>>>shamt, 1100 MULTU, 1101 DIVU; all other codes are undefined.
REQ-019 Accept occurs on any cycle with in_valid && in_ready; a, b, op and shamt are captured on that edge.
REQ-020 States: IDLE, BUSY, DONE; reset state is IDLE.
REQ-021 IDLE, accept of a single-cycle op -> DONE with the registered result; out_valid rises 1 cycle after accept.
REQ-022 IDLE, accept of MULTU/DIVU -> BUSY with iteration counter = WIDTH-1; counter decrements once per cycle; BUSY -> DONE when counter reaches 0; out_valid rises exactly WIDTH+1 cycles after accept.
REQ-023 MULTU: iterative shift-add, unsigned; {hi,y} = a*b, full 2*WIDTH-bit product.
REQ-024 DIVU: iterative restoring division, unsigned; y = a/b, hi = a%b.
REQ-025 DIVU with b = 0: y = all-ones, hi = a; no error flag; same latency as any other DIVU.
REQ-026 Undefined opcode: y = 0, hi = 0, err = 1, latency 1.
REQ-027 ADD/SUB wrap modulo 2^WIDTH; ovf = 1 iff the signed result overflows.
REQ-028 zero is computed from the registered y and is valid whenever out_valid = 1.
REQ-029 DONE with out_ready = 1 -> IDLE, or directly to the next op if a new accept happens in the same cycle.
REQ-030 in_ready = (state == IDLE) || (state == DONE && out_ready); in_ready = 0 throughout BUSY.
REQ-031 While out_valid && !out_ready, y, hi, zero, ovf and err hold stable.
REQ-032 in_valid in BUSY or in stalled DONE is ignored; the operands offered in those cycles are not captured.

Reset
REQ-033 reset_n low immediately (asynchronously) forces state to IDLE, out_valid to 0, and y, hi, zero, ovf, err to 0; the counter clears to 0.
REQ-034 Reset asserted in BUSY aborts the operation; no result is ever presented for it.
REQ-035 The first accept is possible on the first rising edge after reset_n deasserts.

Structure
REQ-036 Package alu_mc_pkg holds op_t (4-bit enum with the REQ-018 codes) and state_t (IDLE/BUSY/DONE).
REQ-037 One sub-module, alu_mc_iter, implements the shared MULTU/DIVU shift-add/restoring engine (start, busy, done, {hi,lo} result); all other logic resides in alu_mc.

Verification
REQ-038 WIDTH=32: ADD a=0x7FFFFFFF, b=1 -> y=0x80000000, ovf=1, zero=0, out_valid 1 cycle after accept.
REQ-039 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, y=0x00000001, out_valid exactly 33 cycles after accept, in_ready=0 throughout BUSY.
REQ-040 DIVU a=100, b=7 -> y=14, hi=2; DIVU a=5, b=0 -> y=0xFFFFFFFF, hi=5.
REQ-041 SUB a=5, b=5 with out_ready held low 4 cycles -> y=0, zero=1, all outputs stable, no new accept; release -> IDLE.
REQ-042 Back-to-back: AND then SRA b=0x80000000, shamt=4 with out_ready=1 -> one result per cycle, second y=0xF8000000.
REQ-043 reset_n low mid-DIVU (cycle 10) -> out_valid=0 immediately; after release, SLT a=-1, b=0 -> y=1; op=1111 -> err=1, y=0.
